mac_row_ctrl: RTL and testbench

Sequencer for one systolic MAC row of `COLUMN` cells. It loads one weight into each column through per-column write enables, then streams a configured number of activations into the row input. It tracks each activation as it ripples through the row's internal x-pass registers and raises a per-column output-valid strobe when that column's accumulated result is on its output bus. It sits between the convolution scheduler (start/config/streams) and the MAC row datapath, and raises `done` once the last result has left the row.

---
 rtl/mac_row_ctrl.sv | 133 +++++++++++++
 tb/tb_mac_row_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_ctrl.sv
// Sequencer for one systolic MAC row: loads per-column weights, streams activations,
// and tracks each fired activation through the row to flag per-column valid results.
module mac_row_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8,
    parameter int unsigned COLUMN  = 6,
    parameter int unsigned MAC_LAT = 1,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_reuse_w,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [WW-1:0]         w_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DW-1:0]         x_data,
    output logic [DW-1:0]         row_xi,
    output logic [COLUMN*WW-1:0]  row_wi,
    output logic [COLUMN-1:0]     row_w_en,
    output logic [COLUMN-1:0]     co_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SR_D = COLUMN + MAC_LAT;
    localparam int unsigned WCW  = $clog2(COLUMN);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_W = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  xcnt_q, xcnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [SR_D-1:1]   taps_q;
    logic [SR_D-2:0]   taps_d;
    logic [SR_D-1:0]   fire_sr;
    logic [COLUMN-1:0] w_onehot;
    logic              w_fire;
    logic              x_fire;

    assign w_ready  = (state_q == LOAD_W);
    // A zero-length reuse job passes through STREAM without ever accepting data.
    assign x_ready  = (state_q == STREAM) && (len_q != '0);
    assign w_fire   = w_ready & w_valid;
    assign x_fire   = x_ready & x_valid;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    assign w_onehot = COLUMN'(1) << wcnt_q;
    assign row_w_en = w_fire ? w_onehot : '0;
    assign row_wi   = w_ready ? {COLUMN{w_data}} : '0;
    assign row_xi   = x_fire ? x_data : '0;

    // Tap 0 is the live fire; taps 1.. are registered copies of it.
    assign fire_sr  = {taps_q, x_fire};
    assign taps_d   = fire_sr[SR_D-2:0];

    for (genvar i = 0; i < COLUMN; i++) begin : g_co_valid
        assign co_valid[i] = fire_sr[i+MAC_LAT];
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        xcnt_d  = xcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    wcnt_d  = '0;
                    xcnt_d  = '0;
                    state_d = cfg_reuse_w ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    if (wcnt_q == WCW'(COLUMN - 1)) begin
                        wcnt_d  = '0;
                        state_d = (len_q == '0) ? DONE : STREAM;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            STREAM: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else if (x_fire) begin
                    if (xcnt_q + LEN_W'(1) == len_q) begin
                        xcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        xcnt_d = xcnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the last result has shifted out of the row.
                if (taps_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            xcnt_q  <= '0;
            wcnt_q  <= '0;
            taps_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            xcnt_q  <= xcnt_d;
            wcnt_q  <= wcnt_d;
            taps_q  <= taps_d;
        end
    end

endmodule

// File: tb/tb_mac_row_ctrl.sv
// Directed self-checking bench for mac_row_ctrl (COLUMN=6, MAC_LAT=1).
module tb_mac_row_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_len;
    logic        cfg_reuse_w;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  x_data;
    logic [7:0]  row_xi;
    logic [47:0] row_wi;
    logic [5:0]  row_w_en;
    logic [5:0]  co_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_b [0:10];
    logic [5:0] exp_c [0:9];
    logic [5:0] exp_e [0:8];

    mac_row_ctrl #(
        .DW(8), .WW(8), .COLUMN(6), .MAC_LAT(1), .LEN_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_reuse_w(cfg_reuse_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .row_xi(row_xi), .row_wi(row_wi), .row_w_en(row_w_en),
        .co_valid(co_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Land 2 time units after the next rising edge; drive, then sample at +3.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input logic [15:0] len, input logic reuse);
        tick();
        start       = 1'b1;
        cfg_len     = len;
        cfg_reuse_w = reuse;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {63'd0, seen}, 64'd1);
        tick();
        #1;
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_b = '{6'h00, 6'h01, 6'h03, 6'h07, 6'h0E, 6'h1C, 6'h38, 6'h30, 6'h20, 6'h00, 6'h00};
        exp_c = '{6'h00, 6'h01, 6'h02, 6'h05, 6'h0A, 6'h14, 6'h28, 6'h10, 6'h20, 6'h00};
        exp_e = '{6'h00, 6'h01, 6'h03, 6'h06, 6'h0C, 6'h18, 6'h30, 6'h20, 6'h00};

        // Reset with random inputs: outputs must clear before any clock edge.
        rst         = 1'b1;
        start       = 1'($urandom);
        cfg_len     = 16'($urandom);
        cfg_reuse_w = 1'($urandom);
        w_valid     = 1'($urandom);
        w_data      = 8'($urandom);
        x_valid     = 1'($urandom);
        x_data      = 8'($urandom);
        #3;
        check("rst_outs", {w_ready, x_ready, row_xi, row_w_en, co_valid, busy, done}, 64'd0);
        check("rst_row_wi", row_wi, 64'd0);
        repeat (2) @(negedge clk);
        start = 1'b0; w_valid = 1'b0; x_valid = 1'b0; cfg_reuse_w = 1'b0;
        rst   = 1'b0;
        tick();
        #1;
        check("idle_after_rst", {62'd0, busy, w_ready}, 64'd0);

        // Job A: weight load with gaps, then 4 back-to-back activations.
        start_job(16'd4, 1'b0);
        #1;
        check("a_busy", {63'd0, busy}, 64'd1);
        check("a_w_ready", {63'd0, w_ready}, 64'd1);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 1) begin
                w_valid = 1'b0;
                w_data  = 8'hEE;
                #1;
                check("a_gap_w_en", {58'd0, row_w_en}, 64'd0);
                tick();
            end
            w_valid = 1'b1;
            w_data  = 8'h11 + 8'(k);
            #1;
            check("a_w_en", {58'd0, row_w_en}, 64'd1 << k);
            check("a_row_wi", row_wi, {16'd0, {6{8'h11 + 8'(k)}}});
            tick();
        end
        w_valid = 1'b0;
        #1;
        check("a_stream_entry", {62'd0, w_ready, x_ready}, 64'd1);
        check("a_row_wi_off", row_wi, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            x_valid = 1'b1;
            x_data  = 8'h30 + 8'(k);
            #1;
            check("a_row_xi", {56'd0, row_xi}, {56'd0, 8'h30 + 8'(k)});
        end
        tick();
        x_valid = 1'b0;
        #1;
        check("a_drain_x_ready", {63'd0, x_ready}, 64'd0);
        tick();
        wait_done("a_done", 20);

        // Job B: reuse, len=3, x_valid held high; start during done is ignored.
        start_job(16'd3, 1'b1);
        for (int c = 0; c <= 10; c++) begin
            x_valid = (c < 4);
            x_data  = 8'hA0 + 8'(c);
            start   = (c == 9);
            #1;
            check("b_co_valid", {58'd0, co_valid}, {58'd0, exp_b[c]});
            check("b_done", {63'd0, done}, {63'd0, c == 9});
            check("b_busy", {63'd0, busy}, {63'd0, c < 10});
            check("b_row_xi", {56'd0, row_xi}, (c < 3) ? {56'd0, 8'hA0 + 8'(c)} : 64'd0);
            check("b_w_ready", {63'd0, w_ready}, 64'd0);
            tick();
        end
        x_valid = 1'b0;
        start   = 1'b0;

        // Job C: bubbles, x_valid 1,0,1.
        start_job(16'd2, 1'b1);
        for (int c = 0; c <= 9; c++) begin
            x_valid = (c == 0 || c == 2);
            x_data  = 8'h5A;
            #1;
            check("c_co_valid", {58'd0, co_valid}, {58'd0, exp_c[c]});
            check("c_done", {63'd0, done}, {63'd0, c == 9});
            if (c == 1) begin
                check("c_bubble_xi", {56'd0, row_xi}, 64'd0);
                check("c_bubble_ready", {63'd0, x_ready}, 64'd1);
            end
            tick();
        end
        x_valid = 1'b0;

        // Job D: weight load with len=0, done right after the last accept.
        start_job(16'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            w_valid = 1'b1;
            w_data  = 8'h21 + 8'(k);
            #1;
            check("d_w_en", {58'd0, row_w_en}, 64'd1 << k);
            tick();
        end
        w_valid = 1'b0;
        #1;
        check("d_done", {63'd0, done}, 64'd1);
        check("d_no_co", {58'd0, co_valid, x_ready, w_ready}, 64'd0);
        tick();
        #1;
        check("d_idle", {63'd0, busy}, 64'd0);

        // Job E: reset after one fire, then a fresh job with a start during STREAM.
        start_job(16'd3, 1'b1);
        x_valid = 1'b1;
        x_data  = 8'h55;
        #1;
        check("e_row_xi", {56'd0, row_xi}, 64'h55);
        tick();
        x_valid = 1'b0;
        #1;
        check("e_co_before_rst", {58'd0, co_valid}, 64'h01);
        #1;
        rst = 1'b1;
        #1;
        check("e_rst_clear", {co_valid, busy, x_ready, row_xi}, 64'd0);
        rst = 1'b0;
        tick();
        #1;
        check("e_idle", {63'd0, busy}, 64'd0);

        start_job(16'd2, 1'b1);
        for (int c = 0; c <= 8; c++) begin
            x_valid = (c < 3);
            x_data  = 8'h70 + 8'(c);
            start   = (c == 1);
            cfg_len = (c == 1) ? 16'd9 : 16'd2;
            #1;
            check("e_x_ready", {63'd0, x_ready}, {63'd0, c < 2});
            check("e_co_valid", {58'd0, co_valid}, {58'd0, exp_e[c]});
            check("e_done", {63'd0, done}, {63'd0, c == 8});
            tick();
        end
        x_valid = 1'b0;
        start   = 1'b0;
        #1;
        check("e_final_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
